// File: rtl/adc_captura_pkg.sv
// Shared definitions for the LTC1407A capture path: FSM states and frame bit map.
package adc_captura_pkg;

  typedef enum logic [1:0] {
    REPOSO,
    CONV,
    LECTURA,
    ESPERA
  } estado_t;

  localparam int unsigned BITS_TRAMA = 34;
  localparam int unsigned POS_A      = 3;
  localparam int unsigned POS_B      = 19;
  localparam int unsigned ADC_ANCHO  = 14;

endpackage

// File: rtl/adc_captura_if.sv
// Control, SPI and sample bus between the ADC capture stage and its neighbours.
interface adc_captura_if
  import adc_captura_pkg::*;
#(
  parameter int unsigned ANCHO = ADC_ANCHO
);

  logic             gain_listo;
  logic             habilitar;
  logic             spi_miso;
  logic             spi_sck;
  logic             ad_conv;
  logic             ocupado;
  logic [ANCHO-1:0] muestra_a;
  logic [ANCHO-1:0] muestra_b;
  logic             valida;

  modport master (
    input  gain_listo, habilitar, spi_miso,
    output spi_sck, ad_conv, ocupado, muestra_a, muestra_b, valida
  );

  modport slave (
    output gain_listo, habilitar, spi_miso,
    input  spi_sck, ad_conv, ocupado, muestra_a, muestra_b, valida
  );

endinterface

// File: rtl/divisor_sck.sv
// SCK tick/phase generator: free-running tick every DIV_SCK clocks, phase toggles while running.
module divisor_sck #(
  parameter int unsigned DIV_SCK = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic i_run,
  output logic o_tick,
  output logic o_fase
);

  localparam int unsigned CW = (DIV_SCK > 1) ? $clog2(DIV_SCK) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_fase;
  logic          w_tick;

  assign w_tick = (r_cnt == CW'(DIV_SCK - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt  <= '0;
      r_fase <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (!i_run)
        r_fase <= 1'b0;
      else if (w_tick)
        r_fase <= ~r_fase;
    end
  end

  assign o_tick = w_tick;
  assign o_fase = r_fase;

endmodule

// File: rtl/adc_captura.sv
// LTC1407A dual-ADC frame sequencer: AD_CONV pulse, 34-clock SCK burst, A/B sample capture.
module adc_captura
  import adc_captura_pkg::*;
#(
  parameter int unsigned DIV_SCK   = 2,
  parameter int unsigned SCK_TRAMA = 64,
  parameter int unsigned ANCHO     = ADC_ANCHO
) (
  input  logic           clock,
  input  logic           resetn,
  adc_captura_if.master  bus
);

  localparam int unsigned FW = $clog2(SCK_TRAMA);

  estado_t          r_estado, w_estado_sig;
  logic             w_tick, w_fase, w_go, w_inicio, w_carga, w_fin_per, w_ultimo;
  logic             w_sube, w_en_a, w_en_b;
  logic [FW-1:0]    r_trama;
  logic [5:0]       r_bits;
  logic [5:0]       w_pos;
  logic [ANCHO-1:0] r_sh_a, r_sh_b, r_mues_a, r_mues_b;
  logic             r_sck, r_conv, r_ocup, r_valida;

  divisor_sck #(.DIV_SCK(DIV_SCK)) u_div (
    .clock  (clock),
    .resetn (resetn),
    .i_run  (r_estado != REPOSO),
    .o_tick (w_tick),
    .o_fase (w_fase)
  );

  assign w_go      = bus.gain_listo & bus.habilitar;
  assign w_fin_per = w_tick & w_fase;
  assign w_ultimo  = (r_trama == FW'(SCK_TRAMA - 1));
  assign w_sube    = (r_estado == LECTURA) & w_tick & ~w_fase;
  assign w_pos     = r_bits + 6'd1;
  // Only the payload bits are kept; the don't-care slots of the 34-bit frame are skipped.
  assign w_en_a    = (w_pos >= 6'(POS_A)) && (w_pos <= 6'(POS_A + ANCHO - 1));
  assign w_en_b    = (w_pos >= 6'(POS_B)) && (w_pos <= 6'(POS_B + ANCHO - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      r_estado <= REPOSO;
    else
      r_estado <= w_estado_sig;
  end

  always_comb begin
    w_estado_sig = r_estado;
    w_inicio     = 1'b0;
    w_carga      = 1'b0;
    unique case (r_estado)
      REPOSO:
        if (w_tick && w_go) begin
          w_estado_sig = CONV;
          w_inicio     = 1'b1;
        end
      CONV:
        if (w_fin_per)
          w_estado_sig = LECTURA;
      LECTURA:
        if (w_fin_per && r_bits == 6'(BITS_TRAMA)) begin
          w_estado_sig = ESPERA;
          w_carga      = 1'b1;
        end
      ESPERA:
        if (w_fin_per && w_ultimo) begin
          if (w_go) begin
            w_estado_sig = CONV;
            w_inicio     = 1'b1;
          end else begin
            w_estado_sig = REPOSO;
          end
        end
      default: w_estado_sig = REPOSO;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_trama  <= '0;
      r_bits   <= '0;
      r_sh_a   <= '0;
      r_sh_b   <= '0;
      r_mues_a <= '0;
      r_mues_b <= '0;
      r_sck    <= 1'b0;
      r_conv   <= 1'b0;
      r_ocup   <= 1'b0;
      r_valida <= 1'b0;
    end else begin
      r_valida <= w_carga;

      if (w_inicio)
        r_trama <= '0;
      else if (w_fin_per)
        r_trama <= w_ultimo ? '0 : r_trama + 1'b1;

      if (w_inicio)
        r_conv <= 1'b1;
      else if (r_estado == CONV && w_fin_per)
        r_conv <= 1'b0;

      if (w_inicio)
        r_ocup <= 1'b1;
      else if (w_carga)
        r_ocup <= 1'b0;

      // SCK only toggles during LECTURA; the CONV period stays low on the pin.
      if (r_estado == LECTURA && w_tick)
        r_sck <= ~w_fase;

      if (r_estado == CONV) begin
        r_bits <= '0;
      end else if (w_sube) begin
        r_bits <= w_pos;
        if (w_en_a) r_sh_a <= {r_sh_a[ANCHO-2:0], bus.spi_miso};
        if (w_en_b) r_sh_b <= {r_sh_b[ANCHO-2:0], bus.spi_miso};
      end

      if (w_carga) begin
        r_mues_a <= r_sh_a;
        r_mues_b <= r_sh_b;
      end
    end
  end

  assign bus.spi_sck   = r_sck;
  assign bus.ad_conv   = r_conv;
  assign bus.ocupado   = r_ocup;
  assign bus.muestra_a = r_mues_a;
  assign bus.muestra_b = r_mues_b;
  assign bus.valida    = r_valida;

endmodule

// File: tb/tb_adc_captura.sv
// Directed bench for adc_captura with a behavioural LTC1407A serial-output model.
module tb_adc_captura;

  logic clock = 1'b0;
  logic resetn;

  adc_captura_if #(.ANCHO(14)) bus ();

  adc_captura #(
    .DIV_SCK   (2),
    .SCK_TRAMA (64),
    .ANCHO     (14)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_ok  = 0;

  int n_ciclo = 0, n_sube = 0, n_conv = 0, n_val = 0, sube_trama = 0, sube_val = 0;
  int t_conv = 0, t_conv_prev = 0, t_val = 0, t_val_prev = 0, ancho_conv = 0;
  int idx = 0;
  logic [13:0] a_cap = '0, b_cap = '0, val_a, val_b;
  logic        ocup_val = 1'b0, sck_p = 1'b0, conv_p = 1'b0;
  logic [33:0] trama = '0;

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor plus ADC model: frame word latched at AD_CONV rise, next bit driven after each SCK fall.
  always @(negedge clock) begin
    n_ciclo++;
    if (bus.ad_conv && !conv_p) begin
      n_conv++;
      t_conv_prev = t_conv;
      t_conv      = n_ciclo;
      sube_trama  = 0;
      trama       = {2'b11, val_a, 2'b11, val_b, 2'b11};
      idx         = 33;
      bus.spi_miso = trama[33];
    end
    if (!bus.ad_conv && conv_p) ancho_conv = n_ciclo - t_conv;
    if (bus.spi_sck && !sck_p) begin
      n_sube++;
      sube_trama++;
    end
    if (!bus.spi_sck && sck_p && idx > 0) begin
      idx--;
      bus.spi_miso = trama[idx];
    end
    if (bus.valida) begin
      n_val++;
      t_val_prev = t_val;
      t_val      = n_ciclo;
      a_cap      = bus.muestra_a;
      b_cap      = bus.muestra_b;
      sube_val   = sube_trama;
      ocup_val   = bus.ocupado;
    end
    sck_p  = bus.spi_sck;
    conv_p = bus.ad_conv;
  end

  task automatic tic(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic esperar_val(input string tag, input int lim);
    int n0 = n_val;
    int k  = 0;
    while (n_val == n0 && k < lim) begin
      tic(1);
      k++;
    end
    comprobar(tag, 32'(n_val != n0), 1);
  endtask

  task automatic esperar_conv(input string tag, input int lim);
    int n0 = n_conv;
    int k  = 0;
    while (n_conv == n0 && k < lim) begin
      tic(1);
      k++;
    end
    comprobar(tag, 32'(n_conv != n0), 1);
  endtask

  task automatic esperar_bit(input string tag, input int bitn, input int lim);
    int k = 0;
    while (sube_trama < bitn && k < lim) begin
      tic(1);
      k++;
    end
    comprobar(tag, sube_trama, bitn);
  endtask

  initial begin
    int nv, nc;
    resetn         = 1'b1;
    bus.gain_listo = 1'b1;
    bus.habilitar  = 1'b1;
    val_a          = 14'h1ABC;
    val_b          = 14'h2345;
    #1 resetn = 1'b0;

    // Held in reset with the block enabled
    tic(20);
    comprobar("rst spi_sck", bus.spi_sck, 0);
    comprobar("rst ad_conv", bus.ad_conv, 0);
    comprobar("rst ocupado", bus.ocupado, 0);
    comprobar("rst muestra_a", bus.muestra_a, 0);
    comprobar("rst muestra_b", bus.muestra_b, 0);
    comprobar("rst valida", bus.valida, 0);
    comprobar("rst sck edges", n_sube, 0);
    comprobar("rst conv edges", n_conv, 0);

    // Gain not ready: stays idle
    bus.gain_listo = 1'b0;
    tic(2);
    resetn = 1'b1;
    tic(500);
    comprobar("idle conv", n_conv, 0);
    comprobar("idle sck", n_sube, 0);

    // First frame
    bus.gain_listo = 1'b1;
    esperar_val("f1 valida", 400);
    comprobar("f1 conv width", ancho_conv, 4);
    comprobar("f1 latency", t_val - t_conv, 140);
    comprobar("f1 muestra_a", a_cap, 14'h1ABC);
    comprobar("f1 muestra_b", b_cap, 14'h2345);
    comprobar("f1 sck rises", sube_val, 34);
    comprobar("f1 ocupado at valida", ocup_val, 0);
    comprobar("f1 valida count", n_val, 1);
    tic(1);
    comprobar("f1 valida one clock", bus.valida, 0);

    // Continuous frames
    for (int i = 0; i < 3; i++) begin
      esperar_val("cont valida", 400);
      comprobar("cont valida period", t_val - t_val_prev, 256);
      comprobar("cont conv period", t_conv - t_conv_prev, 256);
      comprobar("cont sck rises", sube_val, 34);
      comprobar("cont muestra_a", a_cap, 14'h1ABC);
    end

    // habilitar dropped at bit 10: frame completes, then idle
    val_a = 14'h0155;
    val_b = 14'h3AAA;
    esperar_conv("drop conv", 400);
    esperar_bit("drop bit10", 10, 100);
    bus.habilitar = 1'b0;
    nv = n_val;
    esperar_val("drop valida", 300);
    comprobar("drop muestra_a", a_cap, 14'h0155);
    comprobar("drop muestra_b", b_cap, 14'h3AAA);
    comprobar("drop sck rises", sube_val, 34);
    nc = n_conv;
    tic(600);
    comprobar("drop no conv", n_conv, nc);
    comprobar("drop single valida", n_val, nv + 1);
    comprobar("drop sck idle", bus.spi_sck, 0);
    comprobar("drop ocupado idle", bus.ocupado, 0);

    // Reset at bit 20 aborts; next frame clean
    val_a = 14'h3FFF;
    val_b = 14'h2000;
    bus.habilitar = 1'b1;
    esperar_conv("abort conv", 300);
    esperar_bit("abort bit20", 20, 120);
    tic(1);
    nv = n_val;
    resetn = 1'b0;
    #1;
    comprobar("abort spi_sck", bus.spi_sck, 0);
    comprobar("abort ad_conv", bus.ad_conv, 0);
    comprobar("abort ocupado", bus.ocupado, 0);
    comprobar("abort muestra_a", bus.muestra_a, 0);
    comprobar("abort muestra_b", bus.muestra_b, 0);
    comprobar("abort valida", bus.valida, 0);
    tic(5);
    comprobar("abort no valida", n_val, nv);
    resetn = 1'b1;
    esperar_val("post valida", 600);
    comprobar("post muestra_a", a_cap, 14'h3FFF);
    comprobar("post muestra_b", b_cap, 14'h2000);
    comprobar("post sck rises", sube_val, 34);
    comprobar("post valida count", n_val, nv + 1);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
